// File: rtl/axi4_lite_lsu_bridge.sv
// Load/store bridge: RV32 memory stage <-> AXI4-Lite master command port.
// Decodes funct3 width/sign, drives word-aligned address, byte strobes and
// lane-replicated store data, pulses write_start/read_start, stalls the core
// until the master finishes, and returns the sign/zero-extended load lanes.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_read/mem_write       core request levels (held while stall=1)
//   mem_addr/mem_wdata       byte address, store data
//   mem_funct3               access size/sign
//   stall                    combinational pipeline hold
//   load_data/load_valid     registered load result + one-cycle valid
//   access_err               one-cycle pulse: illegal, misaligned or timeout
//   write_*/read_*           master command/response handshake
module axi4_lite_lsu_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [2:0]            mem_funct3,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_valid,
  output logic                  access_err,
  output logic                  write_start,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [3:0]            write_strobe,
  input  logic                  write_busy,
  output logic                  read_start,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  read_busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, ACK, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic                  is_write_q;
  logic [1:0]            lane_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            cnt_q;

  logic                  req, any_req, f3_legal, aligned, accept, reject;
  logic [3:0]            st_strobe;
  logic [DATA_WIDTH-1:0] st_data;
  logic                  busy_sel, tmo_hit, rd_done, tmo_abort;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;
  logic [DATA_WIDTH-1:0] ld_ext;

  // Request decode, alignment check and store lane encoding
  always_comb begin
    any_req  = mem_read | mem_write;
    req      = mem_read ^ mem_write;
    f3_legal = 1'b0;
    if (mem_read) begin
      case (mem_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
        default:                                f3_legal = 1'b0;
      endcase
    end else begin
      case (mem_funct3)
        3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
        default:                f3_legal = 1'b0;
      endcase
    end
    case (mem_funct3[1:0])
      2'b01:   aligned = ~mem_addr[0];
      2'b10:   aligned = (mem_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    // req already excludes read+write together, so reject covers that case
    accept = req & f3_legal & aligned;
    reject = any_req & ~accept;

    case (mem_funct3[1:0])
      2'b00: begin
        st_strobe = 4'b0001 << mem_addr[1:0];
        st_data   = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        st_strobe = 4'b0011 << {mem_addr[1], 1'b0};
        st_data   = {2{mem_wdata[15:0]}};
      end
      default: begin
        st_strobe = 4'hF;
        st_data   = mem_wdata;
      end
    endcase
  end

  // Load lane extraction from the latched offset and funct3
  always_comb begin
    byte_v = 8'(read_data >> {lane_q, 3'b000});
    half_v = 16'(read_data >> {lane_q[1], 4'b0000});
    case (f3_q)
      3'b000:  ld_ext = {{24{byte_v[7]}}, byte_v};
      3'b100:  ld_ext = {24'd0, byte_v};
      3'b001:  ld_ext = {{16{half_v[15]}}, half_v};
      3'b101:  ld_ext = {16'd0, half_v};
      default: ld_ext = read_data;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; progress on busy takes priority over the timeout
  always_comb begin
    state_d   = state_q;
    busy_sel  = is_write_q ? write_busy : read_busy;
    tmo_hit   = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
    rd_done   = 1'b0;
    tmo_abort = 1'b0;
    case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: state_d = ACK;
      ACK: begin
        if (busy_sel) begin
          state_d = WAIT;
        end else if (tmo_hit) begin
          state_d   = DONE;
          tmo_abort = 1'b1;
        end
      end
      WAIT: begin
        if (!busy_sel) begin
          state_d = DONE;
          rd_done = ~is_write_q;
        end else if (tmo_hit) begin
          state_d   = DONE;
          tmo_abort = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    stall       = ((state_q == IDLE) & accept) | (state_q == ISSUE) |
                  (state_q == ACK) | (state_q == WAIT);
    write_start = (state_q == ISSUE) & is_write_q;
    read_start  = (state_q == ISSUE) & ~is_write_q;
  end

  assign write_addr = addr_q;
  assign read_addr  = addr_q;

  // Datapath: request latch, timeout counter, load capture, pulse flags
  always_ff @(posedge clk) begin
    if (rst) begin
      is_write_q   <= 1'b0;
      lane_q       <= '0;
      f3_q         <= '0;
      addr_q       <= '0;
      write_data   <= '0;
      write_strobe <= '0;
      cnt_q        <= '0;
      load_data    <= '0;
      load_valid   <= 1'b0;
      access_err   <= 1'b0;
    end else begin
      load_valid <= rd_done;
      access_err <= ((state_q == IDLE) & reject) | tmo_abort;
      if (state_q == ISSUE)
        cnt_q <= '0;
      else if (state_q == ACK || state_q == WAIT)
        cnt_q <= cnt_q + 8'd1;
      if (state_q == IDLE && accept) begin
        is_write_q   <= mem_write;
        lane_q       <= mem_addr[1:0];
        f3_q         <= mem_funct3;
        addr_q       <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
        write_data   <= st_data;
        write_strobe <= st_strobe;
      end
      if (rd_done)
        load_data <= ld_ext;
    end
  end

endmodule
